// File: rtl/router_top.sv
// Byte-wide 1-in/3-out packet router: header-addressed steering into three FIFOs,
// packet parity checking, input backpressure and per-output timeout flush.
module router_top #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8,
    parameter int TIMEOUT    = 30
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic [2:0]        read_enb,
    input  logic [DATA_W-1:0] datain,
    output logic [2:0]        vld_out,
    output logic              err,
    output logic              busy,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int LEN_W = DATA_W - 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_e;

    state_e              state_q;
    logic [1:0]          addr_q;
    logic [DATA_W-1:0]   header_q, parity_q, xor_q, hold_q;
    logic                hold_vld_q, parity_done_q, drop_q, err_q;

    logic [2:0]          full, empty;
    logic                wr_en;
    logic [DATA_W:0]     wr_data;
    logic [2:0][DATA_W-1:0] dout;

    assign busy       = !(state_q inside {DECODE_ADDRESS, LOAD_DATA});
    assign vld_out    = ~empty;
    assign err        = err_q;
    assign data_out_0 = dout[0];
    assign data_out_1 = dout[1];
    assign data_out_2 = dout[2];

    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            LOAD_FIRST_DATA: begin
                wr_en   = 1'b1;
                wr_data = {1'b1, header_q};
            end
            LOAD_DATA: if (packet_valid && !full[addr_q]) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, datain};
            end
            LOAD_PARITY: if (!full[addr_q]) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, parity_q};
            end
            LOAD_AFTER_FULL: if (hold_vld_q) begin
                wr_en   = 1'b1;
                wr_data = {1'b0, hold_q};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q       <= DECODE_ADDRESS;
            addr_q        <= '0;
            header_q      <= '0;
            parity_q      <= '0;
            xor_q         <= '0;
            hold_q        <= '0;
            hold_vld_q    <= 1'b0;
            parity_done_q <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    // A dropped packet is skipped until its parity byte (packet_valid low).
                    if (drop_q) begin
                        if (!packet_valid) drop_q <= 1'b0;
                    end else if (packet_valid) begin
                        if (datain[1:0] == 2'd3) begin
                            drop_q <= 1'b1;
                        end else begin
                            addr_q        <= datain[1:0];
                            header_q      <= datain;
                            xor_q         <= datain;
                            err_q         <= 1'b0;
                            hold_vld_q    <= 1'b0;
                            parity_done_q <= 1'b0;
                            state_q <= empty[datain[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                        end
                    end
                end
                WAIT_TILL_EMPTY: if (empty[addr_q]) state_q <= LOAD_FIRST_DATA;
                LOAD_FIRST_DATA: state_q <= LOAD_DATA;
                LOAD_DATA: begin
                    if (!packet_valid) begin
                        parity_q <= datain;
                        state_q  <= LOAD_PARITY;
                    end else begin
                        xor_q <= xor_q ^ datain;
                        if (full[addr_q]) begin
                            hold_q     <= datain;
                            hold_vld_q <= 1'b1;
                            state_q    <= FIFO_FULL_STATE;
                        end
                    end
                end
                LOAD_PARITY: begin
                    parity_done_q <= 1'b1;
                    err_q         <= (parity_q != xor_q);
                    if (full[addr_q]) begin
                        hold_q     <= parity_q;
                        hold_vld_q <= 1'b1;
                    end
                    state_q <= CHECK_PARITY_ERROR;
                end
                CHECK_PARITY_ERROR:
                    state_q <= (full[addr_q] || hold_vld_q) ? FIFO_FULL_STATE : DECODE_ADDRESS;
                FIFO_FULL_STATE: if (!full[addr_q]) state_q <= LOAD_AFTER_FULL;
                LOAD_AFTER_FULL: begin
                    hold_vld_q <= 1'b0;
                    if (parity_done_q) begin
                        state_q <= DECODE_ADDRESS;
                    end else if (!packet_valid) begin
                        parity_q <= datain;
                        state_q  <= LOAD_PARITY;
                    end else begin
                        state_q <= LOAD_DATA;
                    end
                end
                default: state_q <= DECODE_ADDRESS;
            endcase
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_out
        logic [DATA_W:0]     mem_q [FIFO_DEPTH];
        logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
        logic [LEN_W:0]      count_q;
        logic [TMR_W-1:0]    timer_q;
        logic [DATA_W-1:0]   dout_q;
        logic [DATA_W:0]     rd_entry;
        logic                we, re, idle_wait, flush;

        assign empty[g]  = (wr_ptr_q == rd_ptr_q);
        assign full[g]   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                           (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        assign we        = wr_en && (addr_q == 2'(g)) && !full[g];
        assign re        = read_enb[g] && !empty[g];
        assign rd_entry  = mem_q[rd_ptr_q[PTR_W-1:0]];
        assign idle_wait = vld_out[g] && !read_enb[g];
        assign flush     = idle_wait && (timer_q == TMR_W'(TIMEOUT - 1));
        assign dout[g]   = dout_q;

        // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
        always_ff @(posedge clk) begin
            if (we) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end

        always_ff @(posedge clk) begin
            if (resetn || flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                dout_q   <= '0;
            end else begin
                if (we) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (re) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    dout_q   <= rd_entry[DATA_W-1:0];
                    // Header read arms the count for payload plus parity.
                    if (rd_entry[DATA_W])   count_q <= {1'b0, rd_entry[DATA_W-1:2]} + 1'b1;
                    else if (count_q != '0) count_q <= count_q - 1'b1;
                end else if (count_q == '0) begin
                    dout_q <= '0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (resetn || !idle_wait || flush) timer_q <= '0;
            else                               timer_q <= timer_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_router_top.sv
// Directed bench for router_top: routing, full-FIFO stall, parity error,
// invalid address drop, read timeout flush and mid-packet reset.
module tb_router_top;

    logic       clk;
    logic       resetn;
    logic       packet_valid;
    logic [2:0] read_enb;
    logic [7:0] datain;
    logic [2:0] vld_out;
    logic       err;
    logic       busy;
    logic [7:0] data_out_0, data_out_1, data_out_2;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    logic [7:0] exp_q[$];

    router_top dut (
        .clk          (clk),
        .resetn       (resetn),
        .packet_valid (packet_valid),
        .read_enb     (read_enb),
        .datain       (datain),
        .vld_out      (vld_out),
        .err          (err),
        .busy         (busy),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] dout_sel(input int port);
        case (port)
            0:       return data_out_0;
            1:       return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    // Header, len payload bytes, then parity = XOR of header and payload.
    function automatic void make_pkt(input int len, input logic [1:0] addr, input bit bad);
        logic [7:0] h, b, p;
        exp_q.delete();
        h = {len[5:0], addr};
        exp_q.push_back(h);
        p = h;
        for (int k = 0; k < len; k++) begin
            b = 8'(k * 29 + len * 3 + 65);
            exp_q.push_back(b);
            p ^= b;
        end
        if (bad) p = ~p;
        exp_q.push_back(p);
    endfunction

    // A byte is consumed on the edge that follows a cycle with busy low.
    task automatic send_byte(input logic [7:0] b, input logic pv);
        logic acc;
        int   guard;
        datain       = b;
        packet_valid = pv;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 300) begin
            @(negedge clk);
            acc = (busy === 1'b0);
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            guard++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept byte=%h busy=%b required busy=0 within 300 cycles", b, busy);
        end
    endtask

    task automatic send_pkt();
        for (int i = 0; i < exp_q.size(); i++)
            send_byte(exp_q[i], (i != exp_q.size() - 1));
        packet_valid = 1'b0;
        datain       = 8'h00;
    endtask

    task automatic read_port(input int port, input int n, input string tag);
        int         got;
        int         guard;
        logic       r;
        logic [7:0] d;
        got   = 0;
        guard = 0;
        read_enb[port] = 1'b1;
        while (got < n && guard < 400) begin
            @(negedge clk);
            r = vld_out[port];
            @(posedge clk);
            #1;
            guard++;
            if (r) begin
                d = dout_sel(port);
                checks++;
                if (d !== exp_q[got]) begin
                    errors++;
                    $display("FAIL %s byte%0d data_out=%h required=%h", tag, got, d, exp_q[got]);
                end
                got++;
            end
        end
        read_enb[port] = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s count got=%0d required=%0d", tag, got, n);
        end
        checks++;
        if (vld_out[port] !== 1'b0) begin
            errors++;
            $display("FAIL %s vld_after_drain vld_out=%b required bit%0d=0", tag, vld_out, port);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dout_sel(port) !== 8'h00) begin
            errors++;
            $display("FAIL %s dout_idle data_out=%h required=00", tag, dout_sel(port));
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({vld_out, busy, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags vld=%b busy=%b err=%b required all 0", vld_out, busy, err);
        end
        checks++;
        if ({data_out_0, data_out_1, data_out_2} !== 24'h0) begin
            errors++;
            $display("FAIL reset_dout got=%h_%h_%h required 0", data_out_0, data_out_1, data_out_2);
        end
        resetn = 1'b0;
    endtask

    task automatic test_route();
        repeat (2) @(posedge clk);
        #1;
        make_pkt(14, 2'd1, 1'b0);
        stalls = 0;
        send_pkt();
        checks++;
        if (stalls != 1) begin
            errors++;
            $display("FAIL route_stalls got=%0d required=1", stalls);
        end
        checks++;
        if (busy !== 1'b1 || vld_out !== 3'b010) begin
            errors++;
            $display("FAIL route_parity_cycle busy=%b vld=%b required busy=1 vld=010", busy, vld_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL route_err err=%b required=0", err);
        end
        @(posedge clk);
        #1;
        read_port(1, 16, "route");
    endtask

    task automatic test_full();
        repeat (2) @(posedge clk);
        #1;
        make_pkt(17, 2'd1, 1'b0);
        fork
            send_pkt();
            begin
                repeat (22) @(posedge clk);
                #1;
                checks++;
                if (busy !== 1'b1 || vld_out !== 3'b010) begin
                    errors++;
                    $display("FAIL full_stall busy=%b vld=%b required busy=1 vld=010", busy, vld_out);
                end
                read_port(1, 19, "full");
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_end err=%b busy=%b required both 0", err, busy);
        end
    endtask

    task automatic test_parity_err();
        repeat (2) @(posedge clk);
        #1;
        make_pkt(8, 2'd2, 1'b1);
        send_pkt();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL perr_early err=%b required=0", err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL perr_set err=%b required=1", err);
        end
        read_port(2, 10, "perr");
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL perr_hold err=%b required=1", err);
        end
    endtask

    task automatic test_bad_addr();
        repeat (2) @(posedge clk);
        #1;
        make_pkt(2, 2'd3, 1'b0);
        stalls = 0;
        send_pkt();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (vld_out !== 3'b000 || busy !== 1'b0 || stalls != 0) begin
            errors++;
            $display("FAIL badaddr vld=%b busy=%b stalls=%0d required 000/0/0", vld_out, busy, stalls);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL badaddr_err_kept err=%b required=1", err);
        end
    endtask

    task automatic test_timeout();
        int n;
        repeat (2) @(posedge clk);
        #1;
        make_pkt(2, 2'd1, 1'b0);
        send_pkt();
        checks++;
        if (err !== 1'b0 || vld_out !== 3'b010) begin
            errors++;
            $display("FAIL tmo_start err=%b vld=%b required err=0 vld=010", err, vld_out);
        end
        n = 0;
        while (vld_out[1] !== 1'b0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 27) begin
            errors++;
            $display("FAIL tmo_flush cycles=%0d required=27", n);
        end
        checks++;
        if (data_out_1 !== 8'h00 || vld_out !== 3'b000) begin
            errors++;
            $display("FAIL tmo_clear dout=%h vld=%b required 00/000", data_out_1, vld_out);
        end
    endtask

    task automatic test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        send_byte(8'h09, 1'b1);
        datain = 8'h55;
        @(posedge clk);
        #1;
        checks++;
        if (vld_out !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_pre vld=%b required=010", vld_out);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        resetn       = 1'b0;
        packet_valid = 1'b0;
        datain       = 8'h00;
        checks++;
        if (busy !== 1'b0 || vld_out !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_post busy=%b vld=%b required 0/000", busy, vld_out);
        end
        make_pkt(8, 2'd0, 1'b0);
        send_pkt();
        read_port(0, 10, "rstmid");
    endtask

    initial begin
        resetn       = 1'b1;
        packet_valid = 1'b0;
        read_enb     = 3'b000;
        datain       = 8'h00;
        test_reset();
        test_route();
        test_full();
        test_parity_err();
        test_bad_addr();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
